ksa_sum_stage: RTL and testbench
================================

Name: ksa_sum_stage

Overview:
- Final (post-processing) stage of the Kogge-Stone adder; sits directly downstream of the prefix tree of grey/black cells.
- Consumes bitwise propagate and per-bit group-carry vectors; forms sum and ALU flags (C, V, N, Z).
- Registers results behind a valid/ready handshake with a 2-entry skid buffer, so the ALU32 pipeline can stall without combinational ready paths.

Parameters:
- W, 32, operand width; legal range 2..64.
- TAG_W, 4, width of the opaque op tag carried alongside the data.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents an entry
- in_ready  out  1  stage can accept; driven directly from a register
- p_in  in  W  bitwise propagate, a[i]^b[i]
- gc_in  in  W  group carry out of bit i (G[i:-1], cin already folded in by the tree)
- cin  in  1  carry into bit 0
- sub  in  1  1 = subtract op; C flag reports borrow
- tag_in  in  TAG_W  op tag, passed through untouched
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- sum_out  out  W  result
- flags_out  out  4  {N,Z,C,V}
- tag_out  out  TAG_W  tag of the result

Behaviour:
- Arithmetic, combinational on the input side:
  - sum[0] = p_in[0]^cin; sum[i] = p_in[i]^gc_in[i-1] for i≥1.
  - cout = gc_in[W-1]; C = sub ? ~cout : cout.
  - V = gc_in[W-1]^gc_in[W-2]; N = sum[W-1]; Z = (sum==0).
- Transfers:
  - Input transfer when in_valid&in_ready.
  - Output transfer when out_valid&out_ready.
  - Latency: 1 cycle from input transfer to out_valid, when empty.
- Skid FSM states: EMPTY, ONE, TWO.
  - EMPTY: in_ready=1, out_valid=0. On input transfer → ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input only → TWO.
    - Output only → EMPTY.
    - Both → ONE; the new entry replaces the output register.
  - TWO: in_ready=0, out_valid=1, second entry held in the skid register. On output transfer → ONE; skid entry moves to the output register.
- Ordering: strict FIFO; no entry dropped or duplicated.
- Input with in_ready=0 is ignored; upstream must hold it. in_valid and payload are stable until accepted.
- out_valid never drops without an output transfer; output payload is stable while out_valid&~out_ready.
- Reset (async assert, any state, including mid-stall):
  - State EMPTY; out_valid=0; in_ready=1.
  - sum_out=0; flags_out=0; tag_out=0.
  - Skid contents discarded.
- Reset release: synchronous to clk; first transfer is possible on the first edge after deassertion.
- X on payload with in_valid=0 must not propagate into registers; payload registers load only on transfer.

Optional Feature:
- Macro: KSA_SUM_OVF_STICKY_EN.
- Enabled:
  - Adds input ovf_clr (1) and output ovf_sticky (1).
  - ovf_sticky sets on any output transfer with V=1 and holds until ovf_clr.
  - Same-cycle set and clr: set wins.
  - Reset value 0.
- Disabled: ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Shared package ksa_pkg:
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Typedef ksa_flags_t (4 bits).
  - Typedef for skid state enum {EMPTY, ONE, TWO}.
  - Default width constant KSA_W=32.
- Sub-module ksa_skid_buf:
  - Generic 2-entry valid/ready skid buffer, parameterised on payload width (W+4+TAG_W).
  - ksa_sum_stage = sum/flag logic + one ksa_skid_buf instance.

Test Plan:
- Overflow, positive to negative (W=32):
  - Stimulus: p_in=0x7FFFFFFE, gc_in=0x7FFFFFFF, cin=0, sub=0, tag=3, out_ready=1.
  - Next cycle: sum_out=0x80000000, N=1, Z=0, C=0, V=1, tag_out=3.
- Carry out with zero result:
  - Stimulus: p_in=0xFFFFFFFE, gc_in=0xFFFFFFFF, cin=0, sub=0.
  - Response: sum_out=0, Z=1, C=1, V=0. With sub=1, same vectors: C=0.
- Backpressure:
  - Stimulus: out_ready=0; present tags 1,2,3 back-to-back.
  - Response: tags 1 and 2 accepted; in_ready=0 from the cycle after tag 2 is accepted; tag 3 held.
  - Release out_ready: outputs 1,2,3 in order, with no bubble between 2 and 3.
- Simultaneous in/out in ONE:
  - Stimulus: in_valid=1 and out_ready=1 every cycle for 8 entries.
  - Response: one result per cycle, in_ready stays 1, state never reaches TWO.
- Reset mid-stall:
  - Stimulus: reach TWO, then pulse rst_n low between edges.
  - Response: out_valid=0, in_ready=1 and all outputs 0 immediately (async). No stale entry emitted after release.
- Sticky overflow (KSA_SUM_OVF_STICKY_EN defined):
  - Stimulus: run the overflow case above.
  - Response: ovf_sticky=1 and held across later non-overflow results.
  - ovf_clr pulse → 0. Clear in the same cycle as a new V=1 transfer → stays 1.

Source files
------------

// File: rtl/ksa_sum_stage_pkg.sv
// Shared types and constants for the Kogge-Stone sum stage (package ksa_pkg).
// Flag bit positions match the {N,Z,C,V} ordering of flags_out.
package ksa_pkg;

    localparam int unsigned KSA_W  = 32;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [3:0] ksa_flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ksa_sum_stage_if.sv
// Valid/ready bus of the sum stage: prefix-tree side (in_*) and result side (out_*).
// slave = the stage itself, master = the environment driving it.
interface ksa_sum_stage_if
    import ksa_pkg::*;
#(
    parameter int unsigned W     = KSA_W,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     p_in;
    logic [W-1:0]     gc_in;
    logic             cin;
    logic             sub;
    logic [TAG_W-1:0] tag_in;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     sum_out;
    ksa_flags_t       flags_out;
    logic [TAG_W-1:0] tag_out;

    modport slave (
        input  in_valid, p_in, gc_in, cin, sub, tag_in, out_ready,
        output in_ready, out_valid, sum_out, flags_out, tag_out
    );

    modport master (
        output in_valid, p_in, gc_in, cin, sub, tag_in, out_ready,
        input  in_ready, out_valid, sum_out, flags_out, tag_out
    );
endinterface

// File: rtl/ksa_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready and out_valid come straight
// from registers so no combinational path runs from i_out_ready to o_in_ready.
module ksa_skid_buf
    import ksa_pkg::*;
#(
    parameter int unsigned DW = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_data
);
    skid_state_e   r_state;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [DW-1:0] r_out;
    logic [DW-1:0] r_skid;

    logic w_in_xfer;
    logic w_out_xfer;

    assign w_in_xfer  = i_in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & i_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_skid      <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        r_out       <= i_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ONE;
                    end
                end
                ONE: begin
                    // Simultaneous in/out: new entry goes straight to the output register.
                    if (w_in_xfer && w_out_xfer) begin
                        r_out <= i_data;
                    end else if (w_in_xfer) begin
                        r_skid     <= i_data;
                        r_in_ready <= 1'b0;
                        r_state    <= TWO;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_out_xfer) begin
                        r_out      <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ONE;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_data      = r_out;
endmodule

// File: rtl/ksa_sum_stage.sv
// Kogge-Stone post-processing: sum and {N,Z,C,V} from propagate/group-carry, then a skid buffer.
// Optional sticky overflow flag (ovf_clr/ovf_sticky) when KSA_SUM_OVF_STICKY_EN is defined.
module ksa_sum_stage
    import ksa_pkg::*;
#(
    parameter int unsigned W     = KSA_W,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef KSA_SUM_OVF_STICKY_EN
    input  logic                 ovf_clr,
    output logic                 ovf_sticky,
`endif
    ksa_sum_stage_if.slave       bus
);
    localparam int unsigned PW = W + 4 + TAG_W;

    logic [W-1:0]  w_carry;
    logic [W-1:0]  w_sum;
    logic          w_cout;
    ksa_flags_t    w_flags;
    logic [PW-1:0] w_in_data;
    logic [PW-1:0] w_out_data;

    // Carry into bit i is the group carry out of bit i-1; bit 0 takes cin.
    assign w_carry = {bus.gc_in[W-2:0], bus.cin};
    assign w_sum   = bus.p_in ^ w_carry;
    assign w_cout  = bus.gc_in[W-1];

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_N] = w_sum[W-1];
        w_flags[FLAG_Z] = (w_sum == '0);
        w_flags[FLAG_C] = bus.sub ? ~w_cout : w_cout;
        w_flags[FLAG_V] = bus.gc_in[W-1] ^ bus.gc_in[W-2];
    end

    assign w_in_data = {w_sum, w_flags, bus.tag_in};

    ksa_skid_buf #(
        .DW (PW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (bus.in_valid),
        .o_in_ready  (bus.in_ready),
        .i_data      (w_in_data),
        .o_out_valid (bus.out_valid),
        .i_out_ready (bus.out_ready),
        .o_data      (w_out_data)
    );

    assign {bus.sum_out, bus.flags_out, bus.tag_out} = w_out_data;

`ifdef KSA_SUM_OVF_STICKY_EN
    logic r_ovf_sticky;
    logic w_ovf_set;

    assign w_ovf_set = bus.out_valid & bus.out_ready & bus.flags_out[FLAG_V];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif
endmodule

// File: tb/tb_ksa_sum_stage.sv
// Directed self-checking bench for ksa_sum_stage (W=32, TAG_W=4).
// Vector table for the arithmetic, hand-written sequences for handshake corners.
module tb_ksa_sum_stage;
    import ksa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ksa_sum_stage_if #(.W(32), .TAG_W(4)) bus ();

`ifdef KSA_SUM_OVF_STICKY_EN
    logic ovf_clr = 1'b0;
    logic ovf_sticky;
`endif

    ksa_sum_stage #(.W(32), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef KSA_SUM_OVF_STICKY_EN
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
`endif
        .bus        (bus.slave)
    );

    typedef struct {
        logic [31:0] p;
        logic [31:0] gc;
        logic        cin;
        logic        sub;
        logic [3:0]  tag;
        logic [31:0] exp_sum;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[8];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] gc,
                         input logic c, input logic s, input logic [3:0] t);
        bus.p_in   = p;
        bus.gc_in  = gc;
        bus.cin    = c;
        bus.sub    = s;
        bus.tag_in = t;
    endtask

    initial begin
        //            p             gc            cin  sub  tag    sum           NZCV
        vecs[0] = '{32'h7FFFFFFE, 32'h7FFFFFFF, 1'b0, 1'b0, 4'h3, 32'h80000000, 4'b1001};
        vecs[1] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h5, 32'h00000000, 4'b0110};
        vecs[2] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b1, 4'h6, 32'h00000000, 4'b0100};
        vecs[3] = '{32'h00000000, 32'h00000001, 1'b0, 1'b0, 4'h7, 32'h00000002, 4'b0000};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 4'h8, 32'h00000001, 4'b0000};
        vecs[5] = '{32'hFFFFFFF9, 32'h00000003, 1'b1, 1'b1, 4'h9, 32'hFFFFFFFE, 4'b1010};
        vecs[6] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 4'hA, 32'hFFFFFFFF, 4'b1010};
        vecs[7] = '{32'h00000000, 32'h80000000, 1'b0, 1'b0, 4'hB, 32'h00000000, 4'b0111};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 4'h0);

        // Reset state
        #12;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_sum",       {32'd0, bus.sum_out},   64'd0);
        chk("rst_flags",     {60'd0, bus.flags_out}, 64'd0);
        chk("rst_tag",       {60'd0, bus.tag_out},   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic table, one entry per cycle with out_ready high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].p, vecs[i].gc, vecs[i].cin, vecs[i].sub, vecs[i].tag);
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {63'd0, bus.out_valid}, 64'd1);
            chk($sformatf("vec%0d_sum", i),   {32'd0, bus.sum_out},   {32'd0, vecs[i].exp_sum});
            chk($sformatf("vec%0d_flags", i), {60'd0, bus.flags_out}, {60'd0, vecs[i].exp_flags});
            chk($sformatf("vec%0d_tag", i),   {60'd0, bus.tag_out},   {60'd0, vecs[i].tag});
        end
        step();
        chk("drain_valid", {63'd0, bus.out_valid}, 64'd0);

        // Payload changes without in_valid must not reach the registers
        drive(32'h12345678, 32'hDEADBEEF, 1'b1, 1'b1, 4'h4);
        step();
        step();
        chk("idle_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("idle_tag",   {60'd0, bus.tag_out},   64'hB);
        chk("idle_flags", {60'd0, bus.flags_out}, 64'b0111);

        // Backpressure: tags 1,2 accepted, 3 held, then drained in order
        bus.out_ready = 1'b0;
        drive(32'd1, 32'd0, 1'b0, 1'b0, 4'd1);
        bus.in_valid = 1'b1;
        step();
        chk("bp_ready_after1", {63'd0, bus.in_ready}, 64'd1);
        drive(32'd2, 32'd0, 1'b0, 1'b0, 4'd2);
        step();
        chk("bp_ready_after2", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_head_tag",     {60'd0, bus.tag_out},  64'd1);
        drive(32'd3, 32'd0, 1'b0, 1'b0, 4'd3);
        step();
        chk("bp_hold_ready", {63'd0, bus.in_ready},  64'd0);
        chk("bp_hold_tag",   {60'd0, bus.tag_out},   64'd1);
        chk("bp_hold_sum",   {32'd0, bus.sum_out},   64'd1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_out2_tag",   {60'd0, bus.tag_out},   64'd2);
        chk("bp_out2_ready", {63'd0, bus.in_ready},  64'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_out3_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_out3_tag",   {60'd0, bus.tag_out},   64'd3);
        chk("bp_out3_sum",   {32'd0, bus.sum_out},   64'd3);
        step();
        chk("bp_empty", {63'd0, bus.out_valid}, 64'd0);

        // Streaming: one result per cycle, in_ready never drops
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(32'h100 + 32'(i), 32'd0, 1'b0, 1'b0, 4'(i));
            step();
            chk($sformatf("str%0d_ready", i), {63'd0, bus.in_ready},  64'd1);
            chk($sformatf("str%0d_sum", i),   {32'd0, bus.sum_out},   64'h100 + 64'(i));
            chk($sformatf("str%0d_valid", i), {63'd0, bus.out_valid}, 64'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("str_drain", {63'd0, bus.out_valid}, 64'd0);

        // Reset mid-stall from TWO
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(32'h55, 32'd0, 1'b0, 1'b0, 4'hD);
        step();
        drive(32'h66, 32'd0, 1'b0, 1'b0, 4'hE);
        step();
        bus.in_valid = 1'b0;
        chk("stall_two", {63'd0, bus.in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mrst_ready", {63'd0, bus.in_ready},  64'd1);
        chk("mrst_sum",   {32'd0, bus.sum_out},   64'd0);
        chk("mrst_flags", {60'd0, bus.flags_out}, 64'd0);
        chk("mrst_tag",   {60'd0, bus.tag_out},   64'd0);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_idle%0d", i), {63'd0, bus.out_valid}, 64'd0);
        end
        drive(32'h77, 32'd0, 1'b0, 1'b0, 4'hC);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("post_rst_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("post_rst_tag",   {60'd0, bus.tag_out},   64'hC);
        step();
        chk("post_rst_drain", {63'd0, bus.out_valid}, 64'd0);

`ifdef KSA_SUM_OVF_STICKY_EN
        chk("stk_after_rst", {63'd0, ovf_sticky}, 64'd0);
        drive(vecs[0].p, vecs[0].gc, 1'b0, 1'b0, 4'h3);
        bus.in_valid = 1'b1;
        step();
        drive(vecs[3].p, vecs[3].gc, 1'b0, 1'b0, 4'h7);
        step();
        bus.in_valid = 1'b0;
        chk("stk_set", {63'd0, ovf_sticky}, 64'd1);
        step();
        step();
        chk("stk_hold", {63'd0, ovf_sticky}, 64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("stk_clr", {63'd0, ovf_sticky}, 64'd0);
        drive(vecs[0].p, vecs[0].gc, 1'b0, 1'b0, 4'h3);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("stk_set_wins", {63'd0, ovf_sticky}, 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
